multicycle_ctrl_fsm: RTL
========================

Name: multicycle_ctrl_fsm

Overview:
- Multi-cycle main control FSM for the 16-bit RISC core. Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives ALUop[1:0] into the ALU control unit, plus PC, IR, register-file and memory-bus enables.
- Handshakes with the shared instruction/data memory through mem_req/mem_ready, with a timeout watchdog.

Parameters:
MEM_TIMEOUT, 15, wait cycles tolerated in FETCH/MEM before faulting; 0 disables the watchdog
TO_W, 4, width of the timeout counter; must satisfy 2^TO_W > MEM_TIMEOUT

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
opcode  in  4  IR[15:12]; valid from DECODE onward
mem_ready  in  1  memory done; sampled only while mem_req=1
reg_eq  in  1  rs==rt from datapath comparator, valid in CTRL
mem_req  out  1  memory access request
mem_we  out  1  write strobe, qualifies mem_req
mem_addr_sel  out  1  0=PC, 1=ALU result register
ir_we  out  1  load IR (and datapath MDR) from memory
pc_we  out  1  PC write enable
pc_src  out  2  00=PC+2, 01=branch target, 10=jump target
ALUop  out  2  to ALU control: 10=LW, 01=SW, 00=R-type
alu_src_b  out  1  0=register, 1=sign-extended immediate
reg_we  out  1  register-file write
wb_sel  out  1  0=ALU result, 1=MDR
retire  out  1  one-cycle pulse per completed instruction
fault  out  1  sticky fault flag
state_o  out  3  current state encoding

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, CTRL=6, FAULT=7.
- Outputs are Moore functions of the registered state and the latched op_q. Exceptions: ir_we, pc_we in FETCH, and retire in MEM also depend on mem_ready.
- Reset: while rst=1, state=IDLE, op_q=0, timeout counter=0, and every output is 0. The first edge after release moves to FETCH.
- Reset mid-operation: an access in flight is abandoned. mem_req drops asynchronously with rst.
- IDLE: all outputs 0; next state FETCH.
- FETCH: mem_req=1, mem_addr_sel=0, mem_we=0.
  - On mem_ready=1: ir_we=1, pc_we=1, pc_src=00 in that same cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: latch op_q<=opcode and classify.
  - 0000 LW and 0001 SW: go to EXEC.
  - 0010..1001 (ALU ops): go to EXEC.
  - 1011 BEQ, 1100 BNE, 1101 JMP: go to CTRL.
  - 1010, 1110, 1111: go to FAULT.
- EXEC: ALUop=10 for LW, 01 for SW, 00 for ALU ops. alu_src_b=1 for LW/SW, 0 otherwise. The ALU result register loads at the end of EXEC. Next state is MEM for LW/SW, WB for ALU ops.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 only for SW. ALUop and alu_src_b hold their EXEC values.
  - On mem_ready with SW: retire=1, go to FETCH.
  - On mem_ready with LW: ir_we=0; the datapath latches the MDR on mem_ready. Go to WB.
- WB: reg_we=1, wb_sel=1 for LW and 0 for ALU ops, retire=1; go to FETCH.
- CTRL:
  - BEQ: pc_we=reg_eq, pc_src=01.
  - BNE: pc_we=~reg_eq, pc_src=01.
  - JMP: pc_we=1, pc_src=10.
  - retire=1 in all three cases; go to FETCH.
- FAULT: fault=1 and all other outputs 0. The state holds until rst.
- Handshake rules:
  - mem_req stays high until mem_ready is seen.
  - mem_addr_sel and mem_we are stable for the whole request.
  - mem_ready when mem_req=0 is ignored.
  - mem_ready in the first request cycle completes that cycle (zero-wait).
- Watchdog (MEM_TIMEOUT>0):
  - The counter clears on entry to FETCH/MEM and increments each cycle with mem_ready=0.
  - If the counter reaches MEM_TIMEOUT with mem_ready still 0, the next state is FAULT.
  - If mem_ready arrives in the cycle the counter equals MEM_TIMEOUT, it wins and no fault is raised.
- Latency with zero-wait memory: ALU op 4 cycles, LW 5, SW 4, BEQ/BNE/JMP 3. Each memory wait cycle adds 1.
- Outputs not listed for a state are 0. ALUop is 00 outside EXEC/MEM.

Test Plan:
- Reset release, mem_ready tied 1, opcode=0010 (ADD) → state_o 0,1,2,3,5,1. ALUop=00 in EXEC. reg_we=1 and wb_sel=0 in WB. retire is a single pulse at cycle 4.
- LW (0000) with mem_ready delayed 3 cycles in MEM → MEM held 4 cycles with mem_req=1, mem_addr_sel=1, mem_we=0, ALUop=10. Then WB with wb_sel=1. Total 8 cycles.
- SW (0001), zero-wait → EXEC has ALUop=01 and alu_src_b=1. MEM has mem_we=1. retire in MEM. Next state FETCH. 4 cycles.
- BEQ (1011) with reg_eq=1, then BNE (1100) with reg_eq=1 → first gives pc_we=1, pc_src=01 in CTRL. Second gives pc_we=0, retire=1. JMP (1101) gives pc_we=1, pc_src=10.
- Opcode 1110, and separately a FETCH with mem_ready held 0 for 16 cycles (MEM_TIMEOUT=15) → state_o=7 and fault=1 sticky. mem_ready=1 arriving at wait count 15 instead gives no fault.
- Assert rst during MEM of an LW → mem_req falls immediately and state_o=0. After release, FETCH is reached in 1 cycle with fault=0.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_fsm
// Description : Main control FSM of the multi-cycle 16-bit RISC core. It
//               sequences fetch/decode/execute/memory/writeback and watches
//               the shared memory handshake with a timeout watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       mem_ready,
    input  logic       reg_eq,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic [1:0] ALUop,
    output logic       alu_src_b,
    output logic       reg_we,
    output logic       wb_sel,
    output logic       retire,
    output logic       fault,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_CTRL   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [TO_W-1:0] c_TO_MAX = MEM_TIMEOUT[TO_W-1:0];
    localparam logic            c_WD_EN  = (MEM_TIMEOUT != 0);

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_op;
    logic [TO_W-1:0] r_cnt;
    logic            w_is_lw;
    logic            w_is_sw;
    logic            w_is_ls;
    logic            w_timeout;
    logic [1:0]      w_aluop;

    assign w_is_lw   = (r_op == 4'b0000);
    assign w_is_sw   = (r_op == 4'b0001);
    assign w_is_ls   = w_is_lw | w_is_sw;
    // A late mem_ready in the last tolerated cycle still completes the access
    assign w_timeout = c_WD_EN && (r_cnt == c_TO_MAX) && !mem_ready;
    assign w_aluop   = w_is_lw ? 2'b10 : (w_is_sw ? 2'b01 : 2'b00);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready)      w_next = S_DECODE;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_DECODE: begin
                case (opcode)
                    4'b1010, 4'b1110, 4'b1111: w_next = S_FAULT;
                    4'b1011, 4'b1100, 4'b1101: w_next = S_CTRL;
                    default:                   w_next = S_EXEC;
                endcase
            end
            S_EXEC:   w_next = w_is_ls ? S_MEM : S_WB;
            S_MEM: begin
                if (mem_ready)      w_next = w_is_sw ? S_FETCH : S_WB;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_WB:     w_next = S_FETCH;
            S_CTRL:   w_next = S_FETCH;
            S_FAULT:  w_next = S_FAULT;
            default:  w_next = S_FAULT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= 4'b0000;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op <= opcode;
            end
            // Any state change restarts the wait count for the next access
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == S_FETCH || r_state == S_MEM) && !mem_ready) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 2'b00;
        ALUop        = 2'b00;
        alu_src_b    = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = 1'b0;
        retire       = 1'b0;
        fault        = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
                pc_we   = mem_ready;
            end
            S_EXEC: begin
                ALUop     = w_aluop;
                alu_src_b = w_is_ls;
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = w_is_sw;
                ALUop        = w_aluop;
                alu_src_b    = w_is_ls;
                retire       = mem_ready & w_is_sw;
            end
            S_WB: begin
                reg_we = 1'b1;
                wb_sel = w_is_lw;
                retire = 1'b1;
            end
            S_CTRL: begin
                retire = 1'b1;
                case (r_op)
                    4'b1011: begin pc_we = reg_eq;  pc_src = 2'b01; end
                    4'b1100: begin pc_we = ~reg_eq; pc_src = 2'b01; end
                    default: begin pc_we = 1'b1;    pc_src = 2'b10; end
                endcase
            end
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

    assign state_o = r_state;

endmodule
`default_nettype wire
